wb_ram_slv: RTL and testbench

Wishbone B4 pipelined slave that terminates the L1 memory-access unit's bus: a byte-enabled on-chip RAM with a fixed, parameterised response latency. It accepts one request per cycle unless stalled and returns acks strictly in request order. It is the simulation and FPGA memory behind the L1 caches and serves both line-fill bursts and single-word nc/write requests.

---
 rtl/wb_ram_slv_pkg.sv | 11 +
 rtl/wb_ram_slv_if.sv | 37 +++
 rtl/wb_ram_slv_sp_ram_be.sv | 44 ++++
 rtl/wb_ram_slv.sv | 110 +++++++++++
 tb/tb_wb_ram_slv.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_ram_slv_pkg.sv
// wb_ram_slv_pkg: bus geometry shared by the on-chip RAM slave and its users.
//   CORE_ADDR_WIDTH : byte-address width of the core bus
//   CORE_DATA_WIDTH : data width of the core bus
//   CORE_BE_WIDTH   : byte-enable width (one bit per data byte)
package wb_ram_slv_pkg;

   localparam int CORE_ADDR_WIDTH = 32;
   localparam int CORE_DATA_WIDTH = 32;
   localparam int CORE_BE_WIDTH   = CORE_DATA_WIDTH / 8;

endpackage : wb_ram_slv_pkg

// File: rtl/wb_ram_slv_if.sv
// wb_ram_slv_if: Wishbone B4 pipelined bus bundle between the L1 memory-access
// unit (master) and the RAM slave.
//   request  : wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
//              wb_lock_i, wb_tga_i, wb_tgc_i   (master -> slave)
//   response : wb_stall_o, wb_ack_o, wb_dat_o, wb_err_o, wb_rty_o
//              (slave -> master)
interface wb_ram_slv_if;
   import wb_ram_slv_pkg::*;

   logic                       wb_cyc_i;
   logic                       wb_stb_i;
   logic                       wb_we_i;
   logic [CORE_ADDR_WIDTH-1:0] wb_adr_i;
   logic [CORE_BE_WIDTH-1:0]   wb_sel_i;
   logic [CORE_DATA_WIDTH-1:0] wb_dat_i;
   logic                       wb_lock_i;
   logic                       wb_tga_i;
   logic                       wb_tgc_i;
   logic                       wb_stall_o;
   logic                       wb_ack_o;
   logic [CORE_DATA_WIDTH-1:0] wb_dat_o;
   logic                       wb_err_o;
   logic                       wb_rty_o;

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
             wb_lock_i, wb_tga_i, wb_tgc_i,
      input  wb_stall_o, wb_ack_o, wb_dat_o, wb_err_o, wb_rty_o
   );

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
             wb_lock_i, wb_tga_i, wb_tgc_i,
      output wb_stall_o, wb_ack_o, wb_dat_o, wb_err_o, wb_rty_o
   );

endinterface : wb_ram_slv_if

// File: rtl/wb_ram_slv_sp_ram_be.sv
// sp_ram_be: single-port RAM with per-byte write enables and a registered
// read port; written so FPGA tools infer block RAM.
//   clk   : clock
//   en    : access strobe (read or write this cycle)
//   we    : 1 = write, 0 = read
//   be    : byte write enables (ignored on reads)
//   addr  : word address
//   wdata : write data
//   rdata : read data, valid the cycle after a read access; holds otherwise
module sp_ram_be #(
   parameter int DWIDTH  = 32,
   parameter int AWIDTH  = 10,
   parameter int BEWIDTH = 4
) (
   input  logic               clk,
   input  logic               en,
   input  logic               we,
   input  logic [BEWIDTH-1:0] be,
   input  logic [AWIDTH-1:0]  addr,
   input  logic [DWIDTH-1:0]  wdata,
   output logic [DWIDTH-1:0]  rdata
);

   localparam int BW = DWIDTH / BEWIDTH;

   logic [DWIDTH-1:0] mem [2**AWIDTH];
   logic [DWIDTH-1:0] rdata_q;

   // Contents are deliberately never reset.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < BEWIDTH; i++) begin
               if (be[i]) mem[addr][i*BW +: BW] <= wdata[i*BW +: BW];
            end
         end else begin
            rdata_q <= mem[addr];
         end
      end
   end

   assign rdata = rdata_q;

endmodule : sp_ram_be

// File: rtl/wb_ram_slv.sv
// wb_ram_slv: Wishbone B4 pipelined slave fronting a byte-enabled on-chip RAM
// with a fixed response latency; acks return strictly in request order.
//   wb_clk_i    : clock
//   wb_rst_i    : synchronous active-high reset (RAM contents kept)
//   stall_inj_i : test hook forcing stall, tie 0 in the SoC
//   wb          : slave side of the Wishbone bundle
// Parameters: MEM_AWIDTH word-address bits, LATENCY accept-to-ack cycles
// (1..4), MAX_OUT maximum accepted-but-unacked requests (>= 1).
module wb_ram_slv
   import wb_ram_slv_pkg::*;
#(
   parameter int MEM_AWIDTH = 10,
   parameter int LATENCY    = 2,
   parameter int MAX_OUT    = 4
) (
   input  logic         wb_clk_i,
   input  logic         wb_rst_i,
   input  logic         stall_inj_i,
   wb_ram_slv_if.slave  wb
);

   localparam int CW = $clog2(MAX_OUT + 1);

   logic                       acc;
   logic                       stall;
   logic                       ack;
   logic [CORE_DATA_WIDTH-1:0] ram_rdata;
   logic [CORE_DATA_WIDTH-1:0] last_dat;
   logic [MEM_AWIDTH-1:0]      word_idx;

   logic [LATENCY-1:0]         vld_pipe_q, vld_pipe_d;
   logic [CW-1:0]              out_cnt_q, out_cnt_d;

   // Stall depends only on the injection hook and the registered count, so it
   // never combinationally loops back through wb_stb_i.
   assign stall    = stall_inj_i | (out_cnt_q == CW'(MAX_OUT));
   assign acc      = wb.wb_cyc_i & wb.wb_stb_i & ~stall;
   assign word_idx = wb.wb_adr_i[MEM_AWIDTH+1:2];

   sp_ram_be #(
      .DWIDTH  (CORE_DATA_WIDTH),
      .AWIDTH  (MEM_AWIDTH),
      .BEWIDTH (CORE_BE_WIDTH)
   ) u_ram (
      .clk   (wb_clk_i),
      .en    (acc),
      .we    (wb.wb_we_i),
      .be    (wb.wb_sel_i),
      .addr  (word_idx),
      .wdata (wb.wb_dat_i),
      .rdata (ram_rdata)
   );

   // Stage 0 data is the RAM output register itself; later stages are flops.
   generate
      if (LATENCY == 1) begin : g_lat1
         assign last_dat = ram_rdata;
      end else begin : g_latn
         logic [LATENCY-2:0][CORE_DATA_WIDTH-1:0] dat_pipe_q, dat_pipe_d;

         always_comb begin
            dat_pipe_d    = dat_pipe_q;
            dat_pipe_d[0] = ram_rdata;
            for (int k = 1; k < LATENCY - 1; k++) dat_pipe_d[k] = dat_pipe_q[k-1];
         end

         always_ff @(posedge wb_clk_i) dat_pipe_q <= dat_pipe_d;

         assign last_dat = dat_pipe_q[LATENCY-2];
      end
   endgenerate

   always_comb begin
      vld_pipe_d    = '0;
      vld_pipe_d[0] = acc;
      for (int k = 1; k < LATENCY; k++) vld_pipe_d[k] = vld_pipe_q[k-1];
      if (!wb.wb_cyc_i) vld_pipe_d = '0;   // abort drops everything in flight
   end

   always_comb begin
      out_cnt_d = out_cnt_q;
      if (!wb.wb_cyc_i)     out_cnt_d = '0;
      else if (acc && !ack) out_cnt_d = out_cnt_q + CW'(1);
      else if (!acc && ack) out_cnt_d = out_cnt_q - CW'(1);
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         vld_pipe_q <= '0;
         out_cnt_q  <= '0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         out_cnt_q  <= out_cnt_d;
      end
   end

   // Ack is masked by cyc in the same cycle so an abort never sees a stray ack;
   // data is zeroed when idle so the bus reads 0 out of reset.
   assign ack           = vld_pipe_q[LATENCY-1] & wb.wb_cyc_i;
   assign wb.wb_ack_o   = ack;
   assign wb.wb_dat_o   = ack ? last_dat : '0;
   assign wb.wb_stall_o = stall;
   assign wb.wb_err_o   = 1'b0;
   assign wb.wb_rty_o   = 1'b0;

   logic unused_ok;
   assign unused_ok = ^{wb.wb_lock_i, wb.wb_tga_i, wb.wb_tgc_i, wb.wb_adr_i[1:0],
                        wb.wb_adr_i[CORE_ADDR_WIDTH-1:MEM_AWIDTH+2]};

endmodule : wb_ram_slv

// File: tb/tb_wb_ram_slv.sv
module tb_wb_ram_slv;
   import wb_ram_slv_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic inj_a = 1'b0;
   logic inj_b = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   cyc_n = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n++;

   wb_ram_slv_if a_if ();
   wb_ram_slv_if b_if ();

   wb_ram_slv #(.MEM_AWIDTH(10), .LATENCY(2), .MAX_OUT(4)) dut_a (
      .wb_clk_i(clk), .wb_rst_i(rst), .stall_inj_i(inj_a), .wb(a_if.slave));

   wb_ram_slv #(.MEM_AWIDTH(10), .LATENCY(3), .MAX_OUT(1)) dut_b (
      .wb_clk_i(clk), .wb_rst_i(rst), .stall_inj_i(inj_b), .wb(b_if.slave));

   // ---------------- scoreboard for DUT A (LATENCY=2) ----------------
   typedef struct {
      logic        wr;
      logic [31:0] dat;
      int          cyc;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] model [0:1023];
   logic [31:0] rd_log[$];
   int          ack_cyc_log[$];
   logic        put_stall;

   always @(negedge clk) begin : mon_a
      exp_t     e;
      logic [9:0] idx;
      if (!a_if.wb_cyc_i) begin
         checks++;
         if (a_if.wb_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL ack_while_cyc_low cycle=%0d ack=%b required=0", cyc_n, a_if.wb_ack_o);
         end
      end
      if (a_if.wb_ack_o === 1'b1) begin
         checks++;
         if (sbq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_ack cycle=%0d ack=1 required=0", cyc_n);
         end else begin
            e = sbq.pop_front();
            if (cyc_n !== e.cyc + 2) begin
               failures++;
               $display("FAIL ack_latency ack_cycle=%0d required=%0d", cyc_n, e.cyc + 2);
            end
            if (!e.wr) begin
               checks++;
               if (a_if.wb_dat_o !== e.dat) begin
                  failures++;
                  $display("FAIL read_data got=%h required=%h", a_if.wb_dat_o, e.dat);
               end
               rd_log.push_back(a_if.wb_dat_o);
            end
            ack_cyc_log.push_back(cyc_n);
         end
      end
      if (rst || !a_if.wb_cyc_i) begin
         sbq.delete();
      end else if (a_if.wb_stb_i && !a_if.wb_stall_o) begin
         idx = a_if.wb_adr_i[11:2];
         if (a_if.wb_we_i) begin
            for (int i = 0; i < 4; i++)
               if (a_if.wb_sel_i[i]) model[idx][i*8 +: 8] = a_if.wb_dat_i[i*8 +: 8];
            sbq.push_back('{wr: 1'b1, dat: 32'h0, cyc: cyc_n});
         end else begin
            sbq.push_back('{wr: 1'b0, dat: model[idx], cyc: cyc_n});
         end
      end
   end

   // one bus cycle on DUT A; inputs change 1 time unit after the edge
   task automatic put(input logic c, input logic s, input logic w,
                      input logic [31:0] ad, input logic [3:0] se, input logic [31:0] d);
      a_if.wb_cyc_i = c;  a_if.wb_stb_i = s;  a_if.wb_we_i = w;
      a_if.wb_adr_i = ad; a_if.wb_sel_i = se; a_if.wb_dat_i = d;
      @(negedge clk);
      put_stall = a_if.wb_stall_o;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) put(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
   endtask

   task automatic clear_logs();
      rd_log.delete();
      ack_cyc_log.delete();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      put(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      put(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      @(negedge clk);
      checks += 4;
      if (a_if.wb_ack_o !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b required=0", a_if.wb_ack_o); end
      if (a_if.wb_stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b required=0", a_if.wb_stall_o); end
      if (a_if.wb_dat_o !== 32'h0) begin failures++; $display("FAIL reset_dat got=%h required=0", a_if.wb_dat_o); end
      if (dut_a.out_cnt_q !== '0) begin failures++; $display("FAIL reset_out_cnt got=%0d required=0", dut_a.out_cnt_q); end
      inj_a = 1'b1;
      #1;
      checks++;
      if (a_if.wb_stall_o !== 1'b1) begin failures++; $display("FAIL reset_stall_inj got=%b required=1", a_if.wb_stall_o); end
      inj_a = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_single();
      int t0;
      clear_logs();
      t0 = cyc_n;
      put(1'b1, 1'b1, 1'b1, 32'h40, 4'hF, 32'hDEADBEEF);
      put(1'b1, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0);
      idle(4);
      checks++;
      if (ack_cyc_log.size() != 2 || ack_cyc_log[0] != t0 + 2 || ack_cyc_log[1] != t0 + 3) begin
         failures++;
         $display("FAIL single_ack_cycles count=%0d first=%0d required=2 acks at %0d,%0d",
                  ack_cyc_log.size(), ack_cyc_log.size() > 0 ? ack_cyc_log[0] : -1, t0 + 2, t0 + 3);
      end
      checks++;
      if (rd_log.size() != 1 || rd_log[0] !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL single_read got=%h required=deadbeef", rd_log.size() > 0 ? rd_log[0] : 32'hx);
      end
   endtask

   task automatic test_byte_en();
      clear_logs();
      put(1'b1, 1'b1, 1'b1, 32'h10, 4'hF, 32'h11223344);
      put(1'b1, 1'b1, 1'b1, 32'h10, 4'b0101, 32'hAABBCCDD);
      put(1'b1, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
      idle(4);
      checks++;
      if (rd_log.size() != 1 || rd_log[0] !== 32'h11BB33DD) begin
         failures++;
         $display("FAIL byte_en got=%h required=11bb33dd", rd_log.size() > 0 ? rd_log[0] : 32'hx);
      end
   endtask

   task automatic test_line_fill();
      int   t0;
      logic stall_seen;
      for (int i = 0; i < 4; i++) put(1'b1, 1'b1, 1'b1, 32'h100 + 32'(4*i), 4'hF, 32'hC0DE0000 + 32'(i));
      idle(3);
      clear_logs();
      stall_seen = 1'b0;
      t0 = cyc_n;
      for (int i = 0; i < 4; i++) begin
         put(1'b1, 1'b1, 1'b0, 32'h100 + 32'(4*i), 4'hF, 32'h0);
         stall_seen |= put_stall;
      end
      idle(4);
      checks++;
      if (stall_seen !== 1'b0) begin failures++; $display("FAIL line_fill_stall got=1 required=0"); end
      checks++;
      if (rd_log.size() != 4) begin
         failures++;
         $display("FAIL line_fill_count got=%0d required=4", rd_log.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_log[i] !== 32'hC0DE0000 + 32'(i) || ack_cyc_log[i] != t0 + 2 + i) begin
               failures++;
               $display("FAIL line_fill_beat%0d data=%h cycle=%0d required data=%h cycle=%0d",
                        i, rd_log[i], ack_cyc_log[i], 32'hC0DE0000 + 32'(i), t0 + 2 + i);
            end
         end
      end
   endtask

   task automatic test_stall_inj();
      put(1'b1, 1'b1, 1'b1, 32'h20, 4'hF, 32'h600DF00D);
      idle(3);
      clear_logs();
      inj_a = 1'b1;
      for (int i = 0; i < 5; i++) begin
         put(1'b1, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
         checks++;
         if (put_stall !== 1'b1 || dut_a.out_cnt_q !== '0) begin
            failures++;
            $display("FAIL stall_inj_hold stall=%b out_cnt=%0d required stall=1 out_cnt=0",
                     put_stall, dut_a.out_cnt_q);
         end
      end
      inj_a = 1'b0;
      put(1'b1, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
      checks++;
      if (put_stall !== 1'b0) begin failures++; $display("FAIL stall_inj_release got=1 required=0"); end
      idle(4);
      checks++;
      if (rd_log.size() != 1 || rd_log[0] !== 32'h600DF00D) begin
         failures++;
         $display("FAIL stall_inj_reads count=%0d required=1 read of 600df00d", rd_log.size());
      end
   endtask

   task automatic test_abort();
      int t1;
      clear_logs();
      put(1'b1, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
      put(1'b1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
      put(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      checks++;
      if (dut_a.out_cnt_q !== '0) begin failures++; $display("FAIL abort_out_cnt got=%0d required=0", dut_a.out_cnt_q); end
      t1 = cyc_n;
      put(1'b1, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0);
      checks++;
      if (put_stall !== 1'b0) begin failures++; $display("FAIL abort_next_accept stall=1 required=0"); end
      idle(4);
      checks++;
      if (rd_log.size() != 1 || rd_log[0] !== 32'hDEADBEEF || ack_cyc_log[0] != t1 + 2) begin
         failures++;
         $display("FAIL abort_acks count=%0d required=1 ack of deadbeef at cycle %0d", rd_log.size(), t1 + 2);
      end
   endtask

   task automatic test_rst_mid();
      clear_logs();
      put(1'b1, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0);
      rst = 1'b1;
      put(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      rst = 1'b0;
      checks++;
      if (dut_a.out_cnt_q !== '0) begin failures++; $display("FAIL rst_mid_out_cnt got=%0d required=0", dut_a.out_cnt_q); end
      idle(4);
      checks++;
      if (ack_cyc_log.size() != 0) begin failures++; $display("FAIL rst_mid_acks got=%0d required=0", ack_cyc_log.size()); end
   endtask

   task automatic test_wrap();
      clear_logs();
      put(1'b1, 1'b1, 1'b1, 32'h1004, 4'hF, 32'h5A5A5A5A);
      put(1'b1, 1'b1, 1'b0, 32'h0004, 4'hF, 32'h0);
      idle(4);
      checks++;
      if (rd_log.size() != 1 || rd_log[0] !== 32'h5A5A5A5A) begin
         failures++;
         $display("FAIL addr_wrap got=%h required=5a5a5a5a", rd_log.size() > 0 ? rd_log[0] : 32'hx);
      end
   endtask

   // DUT B: MAX_OUT=1, LATENCY=3. Stall clears the cycle after the ack, so
   // consecutive accepts land LATENCY+1 = 4 cycles apart.
   task automatic test_max_out();
      int   acc_c[$];
      int   acks;
      int   nacc;
      logic stall_after;
      acks = 0; nacc = 0; stall_after = 1'b0;
      for (int t = 0; t < 40; t++) begin
         b_if.wb_cyc_i = 1'b1;
         b_if.wb_stb_i = (nacc < 3);
         b_if.wb_we_i  = 1'b0;
         b_if.wb_adr_i = 32'(nacc * 4);
         b_if.wb_sel_i = 4'hF;
         @(negedge clk);
         if (b_if.wb_ack_o === 1'b1) acks++;
         if (acc_c.size() == 1 && cyc_n == acc_c[0] + 1) stall_after = b_if.wb_stall_o;
         if (b_if.wb_stb_i && b_if.wb_stall_o === 1'b0) begin
            acc_c.push_back(cyc_n);
            nacc++;
         end
         @(posedge clk);
         #1;
      end
      b_if.wb_cyc_i = 1'b0;
      b_if.wb_stb_i = 1'b0;
      checks++;
      if (stall_after !== 1'b1) begin failures++; $display("FAIL max_out_stall got=%b required=1", stall_after); end
      checks++;
      if (acc_c.size() != 3) begin
         failures++;
         $display("FAIL max_out_accepts got=%0d required=3", acc_c.size());
      end else begin
         checks++;
         if (acc_c[1] - acc_c[0] != 4 || acc_c[2] - acc_c[1] != 4) begin
            failures++;
            $display("FAIL max_out_spacing got=%0d,%0d required=4,4", acc_c[1] - acc_c[0], acc_c[2] - acc_c[1]);
         end
      end
      checks++;
      if (acks != 3) begin failures++; $display("FAIL max_out_acks got=%0d required=3", acks); end
   endtask

   initial begin
      a_if.wb_cyc_i = 1'b0; a_if.wb_stb_i = 1'b0; a_if.wb_we_i = 1'b0;
      a_if.wb_adr_i = '0;   a_if.wb_sel_i = '0;   a_if.wb_dat_i = '0;
      a_if.wb_lock_i = 1'b0; a_if.wb_tga_i = 1'b0; a_if.wb_tgc_i = 1'b0;
      b_if.wb_cyc_i = 1'b0; b_if.wb_stb_i = 1'b0; b_if.wb_we_i = 1'b0;
      b_if.wb_adr_i = '0;   b_if.wb_sel_i = '0;   b_if.wb_dat_i = '0;
      b_if.wb_lock_i = 1'b0; b_if.wb_tga_i = 1'b0; b_if.wb_tgc_i = 1'b0;

      test_reset();
      test_single();
      test_byte_en();
      test_line_fill();
      test_stall_inj();
      test_abort();
      test_rst_mid();
      test_wrap();
      test_max_out();

      checks++;
      if (sbq.size() != 0) begin failures++; $display("FAIL missing_acks pending=%0d required=0", sbq.size()); end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_wb_ram_slv
